// File: rtl/mac_group_scheduler_if.sv
// Handshake/control bundle between the group scheduler and the frame controller / MAC datapath.
// Signal names match the legacy scheduler ports so existing connections map one-to-one.
interface mac_group_scheduler_if #(
  parameter int unsigned TAPS   = 28,
  parameter int unsigned LANES  = 28,
  parameter int unsigned GROUPS = 4
);
  localparam int unsigned PW = $clog2(TAPS);
  localparam int unsigned WW = $clog2(TAPS * GROUPS);
  localparam int unsigned GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  logic          Start;
  logic          Drain_Ready;
  logic          Busy;
  logic          Acc_Clear;
  logic          Acc_En;
  logic [PW-1:0] Pixel_Select;
  logic [WW-1:0] Weight_Select;
  logic [GW-1:0] Group_Select;
  logic [LANES-1:0] Lane_En;
  logic          Drain_Valid;
  logic          Done;

  modport master (
    input  Start, Drain_Ready,
    output Busy, Acc_Clear, Acc_En, Pixel_Select, Weight_Select,
           Group_Select, Lane_En, Drain_Valid, Done
  );

  modport slave (
    output Start, Drain_Ready,
    input  Busy, Acc_Clear, Acc_En, Pixel_Select, Weight_Select,
           Group_Select, Lane_En, Drain_Valid, Done
  );
endinterface

// File: rtl/mac_group_scheduler.sv
// Restartable per-frame sequencer for the shared MAC array: clear, accumulate, settle,
// then drain each lane under valid/ready, once per neuron group.
module mac_group_scheduler #(
  parameter int unsigned TAPS   = 28,
  parameter int unsigned LANES  = 28,
  parameter int unsigned GROUPS = 4,
  parameter int unsigned SETTLE = 6
) (
  input  logic                  clk,
  input  logic                  GlobalReset_n,
  mac_group_scheduler_if.master bus
);
  localparam int unsigned PW = $clog2(TAPS);
  localparam int unsigned WW = $clog2(TAPS * GROUPS);
  localparam int unsigned GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_SETTLE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    tap_q, tap_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [LANES-1:0] lane_q, lane_d;
  logic [GW-1:0]    group_q, group_d;

  always_ff @(posedge clk) begin
    if (!GlobalReset_n) begin
      state_q  <= S_IDLE;
      tap_q    <= '0;
      settle_q <= '0;
      lane_q   <= '0;
      group_q  <= '0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      settle_q <= settle_d;
      lane_q   <= lane_d;
      group_q  <= group_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    settle_d = settle_q;
    lane_d   = lane_q;
    group_d  = group_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          group_d = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        tap_d   = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        if (tap_q == PW'(TAPS - 1)) begin
          settle_d = '0;
          state_d  = S_SETTLE;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_q == SW'(SETTLE - 1)) begin
          lane_d  = LANES'(1);
          state_d = S_DRAIN;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Lane advances only on an accepted transfer; a stall holds every output.
        if (bus.Drain_Ready) begin
          if (lane_q[LANES-1]) begin
            lane_d = '0;
            if (group_q == GW'(GROUPS - 1)) begin
              state_d = S_DONE;
            end else begin
              group_d = group_q + 1'b1;
              state_d = S_CLEAR;
            end
          end else begin
            lane_d = lane_q << 1;
          end
        end
      end
      S_DONE: begin
        group_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode registered state only, so neither Start nor Drain_Ready reaches them combinationally.
  always_comb begin
    bus.Busy          = (state_q != S_IDLE);
    bus.Acc_Clear     = (state_q == S_CLEAR);
    bus.Acc_En        = (state_q == S_MAC);
    bus.Pixel_Select  = '0;
    bus.Weight_Select = '0;
    if (state_q == S_MAC) begin
      bus.Pixel_Select  = tap_q;
      bus.Weight_Select = WW'(group_q) * WW'(TAPS) + WW'(tap_q);
    end
    bus.Group_Select = group_q;
    bus.Lane_En      = lane_q;
    bus.Drain_Valid  = (state_q == S_DRAIN);
    bus.Done         = (state_q == S_DONE);
  end
endmodule

// File: doc/mac_group_scheduler.md
# mac_group_scheduler

Sequences the shared MAC/accumulator array across several neuron groups per input frame. For each group it clears the accumulators, streams the weight and pixel indices through the MAC taps, waits for the datapath pipeline to settle, and then drains the lane results one at a time under a valid/ready handshake. It sits between the frame-level start strobe and the MAC array/weight and pixel muxes, replacing a single-pass free-running cycle counter with a restartable, backpressure-aware FSM.

## Interface
- TAPS, 28: MAC taps per group (pixels per pass); ≥2.
- LANES, 28: accumulator lanes drained per group; ≥2.
- GROUPS, 4: neuron groups per frame; ≥1.
- SETTLE, 6: idle cycles between the last MAC and the first drain; ≥1.
- clk  in  1  the single clock; all logic is rising-edge.
- GlobalReset_n  in  1  synchronous, active-low reset.
- Start  in  1  frame start request; sampled only in IDLE.
- Drain_Ready  in  1  downstream accepts the current lane result.
- Busy  out  1  high from CLEAR of group 0 through DONE inclusive.
- Acc_Clear  out  1  accumulator clear, one cycle per group.
- Acc_En  out  1  MAC accumulate enable.
- Pixel_Select  out  clog2(TAPS)  pixel mux index.
- Weight_Select  out  clog2(TAPS*GROUPS)  weight mux index, equal to group*TAPS + tap.
- Group_Select  out  max(1,clog2(GROUPS))  current group.
- Lane_En  out  LANES  one-hot drain lane enable.
- Drain_Valid  out  1  the selected lane result is valid.
- Done  out  1  one-cycle pulse at frame completion.

## Operation
- States: IDLE, CLEAR, MAC, SETTLE, DRAIN, DONE. Internal counters:
  - tap: 0..TAPS-1
  - settle: 0..SETTLE-1
  - lane: one-hot shift register
  - group: 0..GROUPS-1
- IDLE: all outputs 0. Start=1 → CLEAR with group=0. Start=0 → stay.
- CLEAR: Acc_Clear=1 and Busy=1 for one cycle; tap←0 → MAC.
- MAC, one cycle per tap:
  - Acc_En=1, Pixel_Select=tap, Weight_Select=group*TAPS+tap.
  - At tap==TAPS-1: settle←0 → SETTLE. Otherwise tap+1.
- SETTLE: Acc_En=0, selects=0, for SETTLE cycles. Then Lane_En←1 (lane 0) → DRAIN.
- DRAIN:
  - Drain_Valid=1 and Lane_En is one-hot.
  - On Drain_Valid&&Drain_Ready: Lane_En shifts left by one.
  - When the accepted lane is bit LANES-1, Lane_En←0, then:
    - if group==GROUPS-1 → DONE;
    - otherwise group+1 → CLEAR.
  - Drain_Ready=0 holds Lane_En, Drain_Valid and Group_Select stable with no timeout.
- DONE: Done=1 and Busy=1 for one cycle → IDLE.
- Group_Select = group in every non-IDLE state; 0 in IDLE.
- Pixel_Select and Weight_Select are 0 outside MAC.
- Start is ignored in every state except IDLE, including DONE. It has no queuing.
- Weight_Select arithmetic is unsigned with no wrap. Its maximum is GROUPS*TAPS-1 = 111 at defaults.

## Timing
- All outputs are registered from state and counters (Moore). There is no combinational path from Start or Drain_Ready to any output.
- Reset: GlobalReset_n=0 at a rising edge puts every output at 0 and the state at IDLE on the next cycle. This applies in any state, including mid-MAC and mid-DRAIN. Reset has priority over Start.
- Start high at edge E0 in IDLE gives Busy=1 and Acc_Clear=1 in the cycle after E0.
- First MAC cycle (tap 0) is 2 cycles after E0.
- Per group with Drain_Ready held at 1: 1 + TAPS + SETTLE + LANES cycles. This is 63 at defaults.
- Frame: Busy high for GROUPS*(1+TAPS+SETTLE+LANES)+1 cycles, which is 253 at defaults.
  - Done is in the last of those cycles.
  - The first possible restart (Start accepted) is at the edge ending the cycle after Done.
- Each Drain_Ready=0 cycle during DRAIN extends the frame by exactly one cycle.
- Acc_Clear and Acc_En are never high in the same cycle. Acc_En and Drain_Valid are never high in the same cycle.

## Test plan
- Reset values:
  - Stimulus: hold GlobalReset_n=0 for 3 cycles, with Start=1.
  - Required: all outputs 0 and Busy=0, and Busy remains 0 for the cycle after release if Start drops with the release.
- Single frame, defaults, Drain_Ready=1:
  - Busy is high for exactly 253 cycles and Done pulses once.
  - Acc_Clear pulses 4 times, 63 cycles apart.
  - Group 2, tap 5 shows Weight_Select=61 and Pixel_Select=5.
  - Lane_En walks 1→2^27 once per group.
- Backpressure:
  - Stimulus: Drain_Ready=0 for 10 cycles while Lane_En=1<<7 in group 1.
  - Required: Lane_En, Drain_Valid=1 and Group_Select=1 are held stable; Busy extends to 263 cycles; no lane is skipped or repeated.
- Start while busy: Start pulses during MAC, during DRAIN and in the Done cycle are all ignored. Exactly one Done occurs, and a Start pulse 1 cycle after Done begins a new frame.
- Reset mid-operation:
  - Stimulus: GlobalReset_n=0 for 1 cycle during group 3 DRAIN at lane 12.
  - Required: next cycle shows IDLE with all outputs 0 and no Done; a subsequent Start runs a full 253-cycle frame from group 0.
- Parameter corner: GROUPS=1, TAPS=2, LANES=2, SETTLE=1 gives Busy for 7 cycles, Weight_Select sequence 0,1, and Group_Select constant 0.
